// File: rtl/frame_uart_pkg.sv
// rtl/frame_uart_pkg.sv - shared state type and bit-timing constants for frame_uart
package frame_uart_pkg;

  localparam int CLK_DIVIDER_DEF  = 3;
  localparam int UART_DIVIDER_DEF = 23;
  localparam int DATA_BITS        = 8;
  localparam int HALF_BIT         = ((CLK_DIVIDER_DEF + 1) * (UART_DIVIDER_DEF + 1)) / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Half a bit period in cen pulses for an arbitrary divider pair.
  function automatic int half_bit_cen(input int clk_div, input int uart_div);
    return ((clk_div + 1) * (uart_div + 1)) / 2;
  endfunction

endpackage

// File: rtl/frame_uart_rx.sv
// rtl/frame_uart_rx.sv - 8N1 receiver with input synchroniser and mid-bit sampling
module frame_uart_rx
  import frame_uart_pkg::*;
#(
  parameter logic [4:0] CLK_DIVIDER  = 5'd3,
  parameter logic [4:0] UART_DIVIDER = 5'd23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_error
);

  localparam int         HALF    = half_bit_cen(int'(CLK_DIVIDER), int'(UART_DIVIDER));
  localparam logic [4:0] MID_BIT = 5'((HALF - 1) / (int'(CLK_DIVIDER) + 1));
  localparam logic [4:0] MID_PRE = 5'((HALF - 1) % (int'(CLK_DIVIDER) + 1));

  uart_state_e rx_state, rx_next;
  logic        sync1, sync2, prev;
  logic [4:0]  rx_pre, rx_bit;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift, data_q;
  logic        fall, mid;

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else if (cen) begin
      sync1 <= rx_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev & ~sync2;
  assign mid  = cen && (rx_pre == MID_PRE) && (rx_bit == MID_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= ST_IDLE;
    end else if (cen) begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      ST_IDLE:  if (fall) rx_next = ST_START;
      ST_START: if (mid) rx_next = sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (mid && rx_idx == 3'(DATA_BITS - 1)) rx_next = ST_STOP;
      ST_STOP:  if (mid) rx_next = ST_IDLE;
      default:  rx_next = ST_IDLE;
    endcase
  end

  // Phase counter is held at zero while idle, so it restarts exactly on the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pre   <= '0;
      rx_bit   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      data_q   <= '0;
    end else if (cen) begin
      if (rx_state == ST_IDLE) begin
        rx_pre <= '0;
        rx_bit <= '0;
        rx_idx <= '0;
      end else begin
        if (rx_pre == CLK_DIVIDER) begin
          rx_pre <= '0;
          rx_bit <= (rx_bit == UART_DIVIDER) ? 5'd0 : rx_bit + 5'd1;
        end else begin
          rx_pre <= rx_pre + 5'd1;
        end
        if (mid && rx_state == ST_DATA) begin
          rx_shift <= {sync2, rx_shift[7:1]};
          rx_idx   <= rx_idx + 3'd1;
        end
        if (mid && rx_state == ST_STOP && sync2) begin
          data_q <= rx_shift;
        end
      end
    end
  end

  always_comb begin
    rx_done  = 1'b0;
    rx_error = 1'b0;
    if (rx_state == ST_STOP && mid) begin
      rx_done  = sync2;
      rx_error = ~sync2;
    end
    // The new byte is visible in the same cycle as its strobe.
    rx_data = rx_done ? rx_shift : data_q;
  end

endmodule

// File: rtl/frame_uart.sv
// rtl/frame_uart.sv - 8N1 UART transceiver with byte-wide Tx/Rx strobes
// Define FRAME_UART_LOOPBACK_EN to feed the internal Tx line into the receiver.
module frame_uart
  import frame_uart_pkg::*;
#(
  parameter logic [4:0] CLK_DIVIDER  = 5'd3,
  parameter logic [4:0] UART_DIVIDER = 5'd23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_error,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_state_e tx_state, tx_next;
  logic [4:0]  tx_pre, tx_bit;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;
  logic        rx_in;

  assign tx_bit_end = cen && (tx_pre == CLK_DIVIDER) && (tx_bit == UART_DIVIDER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
    end else if (cen) begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      ST_IDLE:  if (tx_wr) tx_next = ST_START;
      ST_START: if (tx_bit_end) tx_next = ST_DATA;
      ST_DATA:  if (tx_bit_end && tx_idx == 3'(DATA_BITS - 1)) tx_next = ST_STOP;
      ST_STOP:  if (tx_bit_end) tx_next = ST_IDLE;
      default:  tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pre   <= '0;
      tx_bit   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else if (cen) begin
      if (tx_state == ST_IDLE) begin
        tx_pre <= '0;
        tx_bit <= '0;
        tx_idx <= '0;
        if (tx_wr) tx_shift <= tx_data;
      end else begin
        if (tx_pre == CLK_DIVIDER) begin
          tx_pre <= '0;
          tx_bit <= (tx_bit == UART_DIVIDER) ? 5'd0 : tx_bit + 5'd1;
        end else begin
          tx_pre <= tx_pre + 5'd1;
        end
        if (tx_bit_end && tx_state == ST_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= tx_idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    tx_busy = 1'b1;
    tx_done = 1'b0;
    case (tx_state)
      ST_IDLE:  tx_busy = 1'b0;
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = tx_shift[0];
      ST_STOP:  tx_done = tx_bit_end;
      default:  tx_busy = 1'b0;
    endcase
  end

`ifdef FRAME_UART_LOOPBACK_EN
  logic unused_uart_rx;
  assign unused_uart_rx = uart_rx;
  assign rx_in = uart_tx;
`else
  assign rx_in = uart_rx;
`endif

  frame_uart_rx #(
    .CLK_DIVIDER  (CLK_DIVIDER),
    .UART_DIVIDER (UART_DIVIDER)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_error (rx_error)
  );

endmodule

// File: tb/tb_frame_uart.sv
// tb/tb_frame_uart.sv - self-checking bench for frame_uart with a frame-level model
module tb_frame_uart;

`ifdef FRAME_UART_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif
  localparam int BIT   = 96;
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic       uart_rx = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       uart_tx, rx_done, rx_error, tx_busy, tx_done;
  logic [7:0] rx_data;

  frame_uart dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_error (rx_error),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Frame-level model: one Tx frame in flight, and a queue of expected Rx strobes.
  bit         tx_active = 1'b0;
  int         tx_t0 = 0;
  logic [7:0] tx_byte = 8'h00;
  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         early;
    int         late;
  } rx_ev_t;
  rx_ev_t     rxq[$];
  logic [7:0] model_rx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic bit tx_busy_at(input int c);
    return tx_active && c >= tx_t0 && c < tx_t0 + FRAME;
  endfunction

  always @(negedge clk) begin
    bit   eb;
    logic et;
    bit   ed;
    if (!rst_n) begin
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_tx_busy", 32'(tx_busy), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_rx_pulses", 32'({rx_done, rx_error}), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
    end else begin
      eb = tx_busy_at(cyc);
      et = eb ? frame_bit(tx_byte, (cyc - tx_t0) / BIT) : 1'b1;
      ed = eb && (cyc == tx_t0 + FRAME - 1);
      chk("uart_tx", 32'(uart_tx), 32'(et));
      chk("tx_busy", 32'(tx_busy), 32'(eb));
      chk("tx_done", 32'(tx_done), 32'(ed));
      if (rx_done || rx_error) begin
        if (rxq.size() == 0) begin
          chk("rx_spurious_pulse", 32'({rx_done, rx_error}), 32'd0);
        end else begin
          chk("rx_pulse_kind", 32'({rx_done, rx_error}), rxq[0].is_err ? 32'd1 : 32'd2);
          chk("rx_pulse_window", 32'(cyc >= rxq[0].early && cyc <= rxq[0].late), 32'd1);
          if (!rxq[0].is_err) model_rx = rxq[0].data;
          rxq.delete(0);
        end
      end else if (rxq.size() > 0 && cyc > rxq[0].late) begin
        chk("rx_pulse_missing", 32'd0, 32'd1);
        rxq.delete(0);
      end
      chk("rx_data", 32'(rx_data), 32'(model_rx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tx_wr = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // a = first clock edge at which the serial line is seen low.
  task automatic push_rx(input bit is_err, input logic [7:0] b, input int a);
    rx_ev_t ev;
    ev.is_err = is_err;
    ev.data   = b;
    ev.early  = a + 900;
    ev.late   = a + 925;
    rxq.push_back(ev);
  endtask

  task automatic tx_write(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    if (!tx_busy_at(cyc)) begin
      tx_active = 1'b1;
      tx_t0     = cyc + 1;
      tx_byte   = b;
      if (LOOPBACK) push_rx(1'b0, b, tx_t0 + 1);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int tail);
    push_rx(!stop, b, cyc + 1);
    uart_rx = 1'b0;
    ticks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      ticks(BIT);
    end
    uart_rx = stop;
    ticks(BIT + tail);
    uart_rx = 1'b1;
  endtask

  logic exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int t0;
    int n_done;
    int done_at;

    for (int i = 0; i < 12; i++) begin
      uart_rx = i[0];
      tick();
    end
    uart_rx = 1'b1;
    chk("reset_uart_tx_lit", 32'(uart_tx), 32'd1);
    chk("reset_tx_busy_lit", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    ticks(5);

    // 0xA5 frame, with a write attempt mid-frame that must be ignored.
    tx_write(8'hA5);
    t0 = tx_t0;
    n_done = 0;
    done_at = -1;
    while (cyc < t0 + FRAME) begin
      tick();
      if ((cyc - t0) % BIT == 48)
        chk("tx_a5_bit_lit", 32'(uart_tx), 32'(exp_a5[(cyc - t0) / BIT]));
      if (tx_done) begin
        n_done++;
        done_at = cyc - t0;
      end
      if (cyc == t0 + 200) tx_write(8'h33);
    end
    chk("tx_done_count_lit", 32'(n_done), 32'd1);
    chk("tx_done_offset_lit", 32'(done_at), 32'd959);
    chk("tx_busy_after_lit", 32'(tx_busy), 32'd0);

    // Back-to-back write right after busy falls.
    tx_write(8'h96);
    tick();
    chk("b2b_start_low_lit", 32'(uart_tx), 32'd0);
    chk("b2b_busy_lit", 32'(tx_busy), 32'd1);
    ticks(FRAME + 20);

    // Reset in the middle of a frame.
    tx_write(8'h0F);
    ticks(300);
    rst_n = 1'b0;
    tx_active = 1'b0;
    rxq.delete();
    model_rx = 8'h00;
    #1;
    chk("abort_uart_tx_lit", 32'(uart_tx), 32'd1);
    chk("abort_tx_busy_lit", 32'(tx_busy), 32'd0);
    ticks(3);
    rst_n = 1'b1;
    ticks(10);

    if (!LOOPBACK) begin
      tx_write(8'h3C);
      rx_send(8'h5A, 1'b1, 0);
      ticks(200);
      chk("rx_data_5a_lit", 32'(rx_data), 32'h5A);
      rx_send(8'hFF, 1'b0, 200);
      ticks(150);
      chk("rx_data_after_err_lit", 32'(rx_data), 32'h5A);
      uart_rx = 1'b0;
      ticks(20);
      uart_rx = 1'b1;
      ticks(200);
      rx_send(8'h01, 1'b1, 0);
      ticks(200);
      chk("rx_data_01_lit", 32'(rx_data), 32'h01);
    end else begin
      tx_write(8'hC3);
      ticks(FRAME + 100);
      chk("loopback_rx_data_lit", 32'(rx_data), 32'hC3);
    end

    ticks(50);
    chk("rx_all_pulses_seen", 32'(rxq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
